// File: rtl/controle_lavagem.sv
// Wash-cycle sequencer: fill, wash, drain, spin, done.
// Drives the spin request to centrifugacao and the valve, motor, pump and door lock.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           user start, level
//   porta_fechada   door closed sensor
//   nivel_cheio     drum full sensor
//   nivel_vazio     drum empty sensor
//   centrifugar     spin active, from centrifugacao
//   iniciar         spin request, to centrifugacao
//   valvula_agua    fill valve
//   motor_lavar     wash motor
//   bomba           drain pump
//   trava_porta     door lock
//   concluido       cycle finished
//   erro            fault latched
//   estado          current state code
module controle_lavagem #(
  parameter int T_LAVAR        = 20,
  parameter int T_ENCHER_MAX   = 50,
  parameter int T_ESVAZIAR_MAX = 50,
  parameter int PULSO_LEN      = 5,
  parameter int N_REP          = 3,
  parameter int LARG_T         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       porta_fechada,
  input  logic       nivel_cheio,
  input  logic       nivel_vazio,
  input  logic       centrifugar,
  output logic       iniciar,
  output logic       valvula_agua,
  output logic       motor_lavar,
  output logic       bomba,
  output logic       trava_porta,
  output logic       concluido,
  output logic       erro,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    REPOUSO  = 3'd0,
    ENCHER   = 3'd1,
    LAVAR    = 3'd2,
    ESVAZIAR = 3'd3,
    CENTRIF  = 3'd4,
    FIM      = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  localparam logic [LARG_T-1:0] LIM_ENCHER =
    LARG_T'(T_ENCHER_MAX - 1);
  localparam logic [LARG_T-1:0] LIM_LAVAR =
    LARG_T'(T_LAVAR - 1);
  localparam logic [LARG_T-1:0] LIM_ESVAZIAR =
    LARG_T'(T_ESVAZIAR_MAX - 1);
  localparam logic [LARG_T-1:0] LIM_ALTO =
    LARG_T'(N_REP * PULSO_LEN - 1);
  localparam logic [LARG_T-1:0] SAT = '1;

  estado_t           est_q;
  estado_t           est_d;
  logic [LARG_T-1:0] tempo;
  logic [LARG_T-1:0] n_alto;
  logic [1:0]        n_baixo;
  logic              troca;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q <= REPOUSO;
    end else begin
      est_q <= est_d;
    end
  end

  // Next-state logic; an open door wins over every
  // sensor, completion or timeout in the active states.
  always_comb begin
    est_d = est_q;
    case (est_q)
      REPOUSO: begin
        if (start && porta_fechada) begin
          est_d = ENCHER;
        end
      end
      ENCHER: begin
        if (!porta_fechada) begin
          est_d = ERRO;
        end else if (nivel_cheio) begin
          est_d = LAVAR;
        end else if (tempo == LIM_ENCHER) begin
          est_d = ERRO;
        end
      end
      LAVAR: begin
        if (!porta_fechada) begin
          est_d = ERRO;
        end else if (tempo == LIM_LAVAR) begin
          est_d = ESVAZIAR;
        end
      end
      ESVAZIAR: begin
        if (!porta_fechada) begin
          est_d = ERRO;
        end else if (nivel_vazio) begin
          est_d = CENTRIF;
        end else if (tempo == LIM_ESVAZIAR) begin
          est_d = ERRO;
        end
      end
      CENTRIF: begin
        // Leave on the last high sample so iniciar drops
        // on the same edge the peer ends its final pulse.
        if (!porta_fechada) begin
          est_d = ERRO;
        end else if (centrifugar && n_alto == LIM_ALTO) begin
          est_d = FIM;
        end else if (!centrifugar && n_baixo == 2'd2) begin
          est_d = ERRO;
        end
      end
      FIM: begin
        if (!start) begin
          est_d = REPOUSO;
        end
      end
      ERRO: begin
        est_d = ERRO;
      end
      default: begin
        est_d = ERRO;
      end
    endcase
  end

  assign troca = (est_d != est_q);

  // In-state timer and spin handshake counters,
  // all cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tempo   <= '0;
      n_alto  <= '0;
      n_baixo <= '0;
    end else if (troca) begin
      tempo   <= '0;
      n_alto  <= '0;
      n_baixo <= '0;
    end else begin
      if (tempo != SAT) begin
        tempo <= tempo + 1'b1;
      end
      if (est_q == CENTRIF) begin
        if (centrifugar) begin
          if (n_alto != SAT) begin
            n_alto <= n_alto + 1'b1;
          end
          n_baixo <= '0;
        end else if (n_baixo != 2'd3) begin
          n_baixo <= n_baixo + 1'b1;
        end
      end
    end
  end

  // Moore output decode
  always_comb begin
    iniciar      = 1'b0;
    valvula_agua = 1'b0;
    motor_lavar  = 1'b0;
    bomba        = 1'b0;
    trava_porta  = 1'b0;
    concluido    = 1'b0;
    erro         = 1'b0;
    case (est_q)
      REPOUSO: begin
      end
      ENCHER: begin
        valvula_agua = 1'b1;
        trava_porta  = 1'b1;
      end
      LAVAR: begin
        motor_lavar = 1'b1;
        trava_porta = 1'b1;
      end
      ESVAZIAR: begin
        bomba       = 1'b1;
        trava_porta = 1'b1;
      end
      CENTRIF: begin
        iniciar     = 1'b1;
        trava_porta = 1'b1;
      end
      FIM: begin
        concluido = 1'b1;
      end
      default: begin
        erro = 1'b1;
      end
    endcase
  end

  assign estado = est_q;

endmodule

// File: tb/tb_controle_lavagem.sv
// Testbench for controle_lavagem.
// Table-driven cycle vectors checked through a scoreboard queue.
module tb_controle_lavagem;

  localparam int PULSO_LEN = 5;

  typedef struct {
    logic       s;
    logic       p;
    logic       c;
    logic       v;
    logic [2:0] est;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       porta_fechada = 1'b0;
  logic       nivel_cheio = 1'b0;
  logic       nivel_vazio = 1'b0;
  logic       centrifugar;
  logic       iniciar;
  logic       valvula_agua;
  logic       motor_lavar;
  logic       bomba;
  logic       trava_porta;
  logic       concluido;
  logic       erro;
  logic [2:0] estado;

  int total = 0;
  int bad = 0;

  vec_t       tbl[$];
  logic [9:0] sbq[$];

  logic peer_en = 1'b0;
  logic cent;
  int   pcnt;
  logic cnt_en = 1'b0;
  int   n_mot = 0;
  int   n_ini = 0;
  int   n_cen = 0;

  always #5 clk = ~clk;

  controle_lavagem dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .porta_fechada(porta_fechada),
    .nivel_cheio  (nivel_cheio),
    .nivel_vazio  (nivel_vazio),
    .centrifugar  (centrifugar),
    .iniciar      (iniciar),
    .valvula_agua (valvula_agua),
    .motor_lavar  (motor_lavar),
    .bomba        (bomba),
    .trava_porta  (trava_porta),
    .concluido    (concluido),
    .erro         (erro),
    .estado       (estado)
  );

  // centrifugacao peer: PULSO_LEN high, one low, while iniciar
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cent <= 1'b0;
      pcnt <= 0;
    end else if (!iniciar) begin
      cent <= 1'b0;
      pcnt <= 0;
    end else if (cent) begin
      if (pcnt == PULSO_LEN - 1) begin
        cent <= 1'b0;
        pcnt <= 0;
      end else begin
        pcnt <= pcnt + 1;
      end
    end else begin
      cent <= 1'b1;
      pcnt <= 0;
    end
  end

  assign centrifugar = peer_en & cent;

  always @(posedge clk) begin
    if (cnt_en) begin
      if (motor_lavar) n_mot <= n_mot + 1;
      if (iniciar) n_ini <= n_ini + 1;
      if (centrifugar) n_cen <= n_cen + 1;
    end
  end

  function automatic logic [9:0] exp_of(input logic [2:0] st);
    logic tr;
    tr = (st >= 3'd1) && (st <= 3'd4);
    return {st, st == 3'd4, st == 3'd1, st == 3'd2,
            st == 3'd3, tr, st == 3'd5, st == 3'd6};
  endfunction

  function automatic logic [9:0] obs();
    return {estado, iniciar, valvula_agua, motor_lavar,
            bomba, trava_porta, concluido, erro};
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic add(input logic s, input logic p,
                     input logic c, input logic v,
                     input logic [2:0] est, input int n);
    vec_t r;
    r.s = s;
    r.p = p;
    r.c = c;
    r.v = v;
    r.est = est;
    repeat (n) tbl.push_back(r);
  endtask

  task automatic run_tbl(input string nm);
    logic [9:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].s;
      porta_fechada = tbl[i].p;
      nivel_cheio = tbl[i].c;
      nivel_vazio = tbl[i].v;
      sbq.push_back(exp_of(tbl[i].est));
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("%s[%0d]", nm, i), 32'(obs()), 32'(e));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    start = 1'b0;
    porta_fechada = 1'b0;
    nivel_cheio = 1'b0;
    nivel_vazio = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reach CENTRIF: fill, wash 20 cycles, drain.
  task automatic to_centrif();
    add(1, 1, 0, 0, 3'd1, 1);
    add(0, 1, 1, 0, 3'd2, 1);
    add(0, 1, 0, 0, 3'd2, 19);
    add(0, 1, 0, 0, 3'd3, 1);
    add(0, 1, 0, 1, 3'd4, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", 32'(obs()), 32'd0);
    do_reset();

    // 1: normal run with the spin peer
    peer_en = 1'b1;
    cnt_en = 1'b1;
    add(1, 1, 0, 0, 3'd1, 1);
    add(1, 1, 0, 0, 3'd1, 2);
    add(0, 1, 1, 0, 3'd2, 1);
    add(0, 1, 1, 1, 3'd2, 19);
    add(0, 1, 1, 1, 3'd3, 1);
    add(0, 1, 0, 0, 3'd3, 4);
    add(0, 1, 0, 1, 3'd4, 1);
    add(0, 1, 0, 0, 3'd4, 17);
    add(0, 1, 0, 0, 3'd5, 1);
    add(1, 1, 0, 0, 3'd5, 2);
    add(0, 1, 0, 0, 3'd0, 3);
    run_tbl("normal");
    cnt_en = 1'b0;
    check("motor_cycles", n_mot, 32'd20);
    check("iniciar_cycles", n_ini, 32'd18);
    check("centrif_cycles", n_cen, 32'd15);
    check("centrif_after", 32'(centrifugar), 32'd0);

    // 2: start with door open is ignored
    do_reset();
    add(1, 0, 0, 0, 3'd0, 10);
    run_tbl("door_open_start");

    // 3: fill timeout
    do_reset();
    add(1, 1, 0, 0, 3'd1, 1);
    add(1, 1, 0, 0, 3'd1, 49);
    add(1, 1, 0, 0, 3'd6, 2);
    run_tbl("fill_timeout");

    // 4: door opens during wash at tempo 7
    do_reset();
    add(1, 1, 0, 0, 3'd1, 1);
    add(0, 1, 1, 0, 3'd2, 1);
    add(0, 1, 0, 0, 3'd2, 7);
    add(0, 0, 0, 0, 3'd6, 1);
    add(0, 1, 0, 0, 3'd6, 1);
    run_tbl("door_in_wash");

    // door open beats nivel_cheio in the same cycle
    do_reset();
    add(1, 1, 0, 0, 3'd1, 1);
    add(1, 0, 1, 0, 3'd6, 1);
    run_tbl("door_beats_full");

    // 5: peer silent -> error on third low sample
    do_reset();
    peer_en = 1'b0;
    to_centrif();
    add(0, 1, 0, 0, 3'd4, 2);
    add(0, 1, 0, 0, 3'd6, 2);
    run_tbl("spin_silent");

    // 6: asynchronous reset in the middle of CENTRIF
    do_reset();
    peer_en = 1'b1;
    to_centrif();
    add(0, 1, 0, 0, 3'd4, 5);
    run_tbl("to_spin");
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(obs()), 32'd0);
    check("async_reset_peer", 32'(centrifugar), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset", 32'(obs()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
